multi_port_register_file: RTL and testbench
===========================================

// Module: multi_port_register_file
// PURPOSE
//  Parametrised successor to the single-read-pair/single-writer register file.
//  Architectural integer register array with NUM_RD read ports and NUM_WR write ports.
//  Adds a per-register busy scoreboard (reserve at decode, release at write-back) and a flush.
//  Sits between DecodeStage (reads, reserves) and WriteBackStage (writes).
// PARAMETERS
//  DATA_WIDTH  32                  width of each register / data port
//  NUM_REGS    32                  number of architectural registers, power of two, >=2
//  ADDR_WIDTH  $clog2(NUM_REGS)    register address width (derived, do not override)
//  NUM_RD      2                   read ports, 1..4
//  NUM_WR      1                   write ports, 1..2
// PORTS
//  clk       in   1                      clock, all state updates on rising edge
//  rst       in   1                      asynchronous reset, active-low
//  rdAddr    in   NUM_RD*ADDR_WIDTH      read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  rdData    out  NUM_RD*DATA_WIDTH      read data, combinational
//  rdBusy    out  NUM_RD                 1 = addressed register has an outstanding producer
//  wrEn      in   NUM_WR                 write enable per write port
//  wrAddr    in   NUM_WR*ADDR_WIDTH      write addresses
//  wrData    in   NUM_WR*DATA_WIDTH      write data
//  rsvEn     in   1                      reserve: mark rsvAddr busy
//  rsvAddr   in   ADDR_WIDTH             register to reserve
//  flush     in   1                      synchronous clear of all busy bits
//  busyCnt   out  ADDR_WIDTH+1           number of registers currently busy (registered)
// BEHAVIOUR
//  - Reset (rst==0, async): all registers 0, all busy bits 0, busyCnt 0; rdData reads 0, rdBusy 0.
//  - Register 0 is hard-wired zero: writes ignored, never reserved, rdData=0 and rdBusy=0 always.
//  - Read: rdData[i] = reg[rdAddr[i]] of current state, zero-cycle latency.
//  - Write: on edge, each wrEn[j] with wrAddr[j]!=0 stores wrData[j].
//    Same address on several ports: highest port index wins.
//  - Write also clears busy[wrAddr[j]], unless it is overridden below.
//  - Reserve: rsvEn with rsvAddr!=0 sets busy[rsvAddr] on the edge.
//    Same-cycle reserve and write to one address: data is written AND busy ends set
//    (the newer producer wins).
//  - flush=1: all busy bits cleared on the edge, overriding reserve.
//    Register writes in the same cycle still happen.
//  - busyCnt: equals the popcount of the busy vector after every edge.
//    Updated incrementally (+1 reserve of non-busy reg, -1 per distinct released busy reg);
//    forced to 0 on flush. Never exceeds NUM_REGS-1.
//  - Reserving an already-busy register: no change to busy or busyCnt.
//    Writing a non-busy register: busy stays 0, busyCnt unchanged.
//  - Reset asserted mid-operation: state clears immediately, independent of clk.
// CONFIGURATION
//  RF_WRITE_BYPASS_EN defined:
//    - If any wrEn[j] matches rdAddr[i] (nonzero), rdData[i] = wrData[j] (highest j) in the same cycle.
//    - rdBusy[i] = 0 in that case unless the same address is being reserved that cycle.
//  Undefined:
//    - Reads return pre-edge array contents.
//    - rdBusy reflects the current busy bit only; the written value is visible the next cycle.
// TESTING
//  1. Release rst, read all regs on every port -> rdData=0, rdBusy=0, busyCnt=0.
//  2. wr x5=0xDEADBEEF; next cycle read x5 on ports 0 and 1 -> 0xDEADBEEF on both;
//     wr x0=0x1234 -> x0 reads 0.
//  3. Reserve x3 -> next cycle rdBusy=1, busyCnt=1; wr x3=7 -> busy clears, busyCnt=0, reads 7.
//  4. Same cycle: reserve x4 and write x4=9 -> x4 reads 9, rdBusy=1, busyCnt=1.
//  5. NUM_WR=2, both ports write x6 (0x11, 0x22) -> x6=0x22.
//     With RF_WRITE_BYPASS_EN, same-cycle read of x6 returns 0x22; without it, returns the old value.
//  6. Reserve x1..x10, then flush with rsvEn on x11 -> busyCnt=0, no reg busy;
//     rst pulse mid-run -> all regs 0 immediately.

Source files
------------

// File: rtl/multi_port_register_file.sv
`default_nettype none
// ============================================================================
// Module   : multi_port_register_file
// Brief    : Architectural register array with NUM_RD combinational read
//            ports, NUM_WR write ports, a per-register busy scoreboard
//            (reserve at decode, release at write-back), flush, and a
//            registered busy count. Register 0 is hard-wired to zero.
// Options  : RF_WRITE_BYPASS_EN - forward same-cycle write data to reads
// Revision : 1.0 - initial release
// ============================================================================
module multi_port_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   parameter int ADDR_WIDTH = $clog2(NUM_REGS),
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rdAddr,
   output logic [NUM_RD*DATA_WIDTH-1:0] rdData,
   output logic [NUM_RD-1:0]            rdBusy,
   input  logic [NUM_WR-1:0]            wrEn,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] wrAddr,
   input  logic [NUM_WR*DATA_WIDTH-1:0] wrData,
   input  logic                         rsvEn,
   input  logic [ADDR_WIDTH-1:0]        rsvAddr,
   input  logic                         flush,
   output logic [ADDR_WIDTH:0]          busyCnt
);

   localparam int c_CNT_W = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] r_regs    [NUM_REGS];
   logic [DATA_WIDTH-1:0] w_regsNxt [NUM_REGS];
   logic [NUM_REGS-1:0]   r_busy;
   logic [NUM_REGS-1:0]   w_busyNxt;
   logic [NUM_REGS-1:0]   w_rel;
   logic [c_CNT_W-1:0]    r_busyCnt;
   logic [c_CNT_W-1:0]    w_cntNxt;
   logic [c_CNT_W-1:0]    w_relCnt;
   logic                  w_rsvValid;
   logic                  w_rsvInc;

   logic [ADDR_WIDTH-1:0] w_wrAddr  [NUM_WR];
   logic [DATA_WIDTH-1:0] w_wrData  [NUM_WR];
   logic [NUM_WR-1:0]     w_wrValid;

   // Unpack write ports; a write to register 0 is treated as no write at all
   for (genvar gj = 0; gj < NUM_WR; gj++) begin : g_wr
      assign w_wrAddr[gj]  = wrAddr[gj*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wrData[gj]  = wrData[gj*DATA_WIDTH +: DATA_WIDTH];
      assign w_wrValid[gj] = wrEn[gj] && (w_wrAddr[gj] != '0);
   end

   assign w_rsvValid = rsvEn && (rsvAddr != '0);

   // Next register contents: ports applied in ascending order so the highest index wins
   always_comb begin
      w_regsNxt = r_regs;
      for (int j = 0; j < NUM_WR; j++) begin
         if (w_wrValid[j]) begin
            w_regsNxt[w_wrAddr[j]] = w_wrData[j];
         end
      end
   end

   // Next busy vector and count: writes release, reserve re-sets (newer producer), flush clears all
   always_comb begin
      w_busyNxt = r_busy;
      w_rel     = '0;
      for (int j = 0; j < NUM_WR; j++) begin
         if (w_wrValid[j]) begin
            w_busyNxt[w_wrAddr[j]] = 1'b0;
            w_rel[w_wrAddr[j]]     = r_busy[w_wrAddr[j]];
         end
      end
      if (w_rsvValid) begin
         w_busyNxt[rsvAddr] = 1'b1;
         w_rel[rsvAddr]     = 1'b0;
      end
      w_busyNxt[0] = 1'b0;
      w_rel[0]     = 1'b0;
      if (flush) begin
         w_busyNxt = '0;
      end

      // Distinct released registers (the mask collapses duplicate write addresses)
      w_relCnt = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         w_relCnt = w_relCnt + {{ADDR_WIDTH{1'b0}}, w_rel[k]};
      end
      w_rsvInc = w_rsvValid && !r_busy[rsvAddr];

      if (flush) begin
         w_cntNxt = '0;
      end else begin
         w_cntNxt = r_busyCnt + {{ADDR_WIDTH{1'b0}}, w_rsvInc} - w_relCnt;
      end
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            r_regs[k] <= '0;
         end
         r_busy    <= '0;
         r_busyCnt <= '0;
      end else begin
         r_regs    <= w_regsNxt;
         r_busy    <= w_busyNxt;
         r_busyCnt <= w_cntNxt;
      end
   end

   assign busyCnt = r_busyCnt;

   // Read ports: combinational lookup, register 0 forced to zero / not busy
   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_a;
      logic [DATA_WIDTH-1:0] w_data;
      logic                  w_busy;

      assign w_a = rdAddr[gi*ADDR_WIDTH +: ADDR_WIDTH];

      // Array lookup, optionally overridden by a same-cycle write to the same register
      always_comb begin
         w_data = (w_a == '0) ? '0 : r_regs[w_a];
         w_busy = (w_a == '0) ? 1'b0 : r_busy[w_a];
`ifdef RF_WRITE_BYPASS_EN
         for (int j = 0; j < NUM_WR; j++) begin
            if (w_wrValid[j] && (w_wrAddr[j] == w_a)) begin
               w_data = w_wrData[j];
               w_busy = w_rsvValid && (rsvAddr == w_a);
            end
         end
`else
         // Without bypass the written value and busy release appear next cycle
`endif
      end

      assign rdData[gi*DATA_WIDTH +: DATA_WIDTH] = w_data;
      assign rdBusy[gi]                          = w_busy;
   end

endmodule
`default_nettype wire

// File: tb/tb_multi_port_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_port_register_file
// Brief    : Directed and random stimulus for multi_port_register_file
//            (NUM_RD=2, NUM_WR=2) against an array/bitvector reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_port_register_file;

   localparam int DW = 32;
   localparam int NR = 32;
   localparam int AW = 5;

   logic           clk = 1'b0;
   logic           rst;
   logic [2*AW-1:0] rdAddr;
   wire  [2*DW-1:0] rdData;
   wire  [1:0]      rdBusy;
   logic [1:0]      wrEn;
   logic [2*AW-1:0] wrAddr;
   logic [2*DW-1:0] wrData;
   logic            rsvEn;
   logic [AW-1:0]   rsvAddr;
   logic            flush;
   wire  [AW:0]     busyCnt;

   multi_port_register_file #(
      .DATA_WIDTH (DW),
      .NUM_REGS   (NR),
      .NUM_RD     (2),
      .NUM_WR     (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .rdAddr  (rdAddr),
      .rdData  (rdData),
      .rdBusy  (rdBusy),
      .wrEn    (wrEn),
      .wrAddr  (wrAddr),
      .wrData  (wrData),
      .rsvEn   (rsvEn),
      .rsvAddr (rsvAddr),
      .flush   (flush),
      .busyCnt (busyCnt)
   );

   always #5 clk = ~clk;

   // Reference model: plain register array and busy set
   logic [DW-1:0] m_regs [NR];
   logic [NR-1:0] m_busy;
   int passes = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int k = 0; k < NR; k++) m_regs[k] = '0;
      m_busy = '0;
   endtask

   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
      logic [DW-1:0] d;
      d = (a == 0) ? '0 : m_regs[a];
`ifdef RF_WRITE_BYPASS_EN
      for (int j = 0; j < 2; j++)
         if (wrEn[j] && a != 0 && wrAddr[j*AW +: AW] == a) d = wrData[j*DW +: DW];
`endif
      return d;
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      logic b;
      b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef RF_WRITE_BYPASS_EN
      for (int j = 0; j < 2; j++)
         if (wrEn[j] && a != 0 && wrAddr[j*AW +: AW] == a) b = rsvEn && (rsvAddr == a);
`endif
      return b;
   endfunction

   task automatic check_reads();
      for (int i = 0; i < 2; i++) begin
         logic [AW-1:0] a;
         a = rdAddr[i*AW +: AW];
         chk($sformatf("rdData%0d x%0d", i, a), 64'(rdData[i*DW +: DW]), 64'(exp_data(a)));
         chk($sformatf("rdBusy%0d x%0d", i, a), 64'(rdBusy[i]), 64'(exp_busy(a)));
      end
   endtask

   // Spec rules at the clock edge
   task automatic model_edge();
      for (int j = 0; j < 2; j++) begin
         logic [AW-1:0] wa;
         wa = wrAddr[j*AW +: AW];
         if (wrEn[j] && wa != 0) begin
            m_regs[wa] = wrData[j*DW +: DW];
            m_busy[wa] = 1'b0;
         end
      end
      if (rsvEn && rsvAddr != 0) m_busy[rsvAddr] = 1'b1;
      if (flush) m_busy = '0;
   endtask

   // Called at a falling edge: check reads, take the edge, check the count
   task automatic step();
      #1;
      check_reads();
      @(posedge clk);
      model_edge();
      #1;
      chk("busyCnt", 64'(busyCnt), 64'($countones(m_busy)));
      @(negedge clk);
   endtask

   task automatic op(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                     input logic [1:0] we, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                     input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                     input logic rv, input logic [AW-1:0] ra, input logic fl);
      rdAddr  = {r1, r0};
      wrEn    = we;
      wrAddr  = {wa1, wa0};
      wrData  = {wd1, wd0};
      rsvEn   = rv;
      rsvAddr = ra;
      flush   = fl;
      step();
   endtask

   task automatic idle_read(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
      op(r0, r1, 2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0);
   endtask

   function automatic logic [AW-1:0] raddr();
      return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NR-1)) : AW'($urandom_range(0, 7));
   endfunction

   initial begin
      rst = 1'b0; rdAddr = '0; wrEn = '0; wrAddr = '0; wrData = '0;
      rsvEn = 1'b0; rsvAddr = '0; flush = 1'b0;
      model_reset();

      // Reset state: every register on both ports reads zero and not busy
      for (int a = 0; a < NR; a++) begin
         rdAddr = {AW'(a), AW'(a)};
         #1;
         chk($sformatf("rst rd0 x%0d", a), 64'(rdData[DW-1:0]), 64'd0);
         chk($sformatf("rst rd1 x%0d", a), 64'(rdData[2*DW-1:DW]), 64'd0);
         chk($sformatf("rst busy x%0d", a), 64'(rdBusy), 64'd0);
      end
      chk("rst busyCnt", 64'(busyCnt), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Write x5, read back on both ports; write to x0 is ignored
      op(5, 5, 2'b01, 5, 0, 32'hDEADBEEF, 0, 1'b0, 0, 1'b0);
      idle_read(5, 5);
      chk("x5 port0", 64'(rdData[DW-1:0]), 64'hDEADBEEF);
      chk("x5 port1", 64'(rdData[2*DW-1:DW]), 64'hDEADBEEF);
      op(0, 0, 2'b01, 0, 0, 32'h1234, 0, 1'b0, 0, 1'b0);
      idle_read(0, 0);
      chk("x0 reads 0", 64'(rdData), 64'd0);

      // Reserve then release x3
      op(3, 3, 2'b00, 0, 0, 0, 0, 1'b1, 3, 1'b0);
      idle_read(3, 3);
      chk("x3 busy", 64'(rdBusy), 64'b11);
      chk("x3 busyCnt", 64'(busyCnt), 64'd1);
      op(3, 3, 2'b01, 3, 0, 32'd7, 0, 1'b0, 0, 1'b0);
      idle_read(3, 3);
      chk("x3 released cnt", 64'(busyCnt), 64'd0);
      chk("x3 data", 64'(rdData[DW-1:0]), 64'd7);
      chk("x3 not busy", 64'(rdBusy), 64'b00);

      // Same-cycle reserve and write of x4: data lands, busy stays set
      op(4, 4, 2'b01, 4, 0, 32'd9, 0, 1'b1, 4, 1'b0);
      idle_read(4, 4);
      chk("x4 data", 64'(rdData[DW-1:0]), 64'd9);
      chk("x4 busy", 64'(rdBusy), 64'b11);
      chk("x4 busyCnt", 64'(busyCnt), 64'd1);

      // Two ports write x6: higher port wins (same-cycle read depends on bypass)
      op(6, 6, 2'b11, 6, 6, 32'h11, 32'h22, 1'b0, 0, 1'b0);
      idle_read(6, 6);
      chk("x6 data", 64'(rdData[DW-1:0]), 64'h22);

      // Reserve x1..x10, then flush with a concurrent reserve of x11
      for (int a = 1; a <= 10; a++) op(AW'(a), 4, 2'b00, 0, 0, 0, 0, 1'b1, AW'(a), 1'b0);
      chk("ten busy", 64'(busyCnt), 64'd10);
      op(11, 1, 2'b00, 0, 0, 0, 0, 1'b1, 11, 1'b1);
      idle_read(11, 1);
      chk("flush cnt", 64'(busyCnt), 64'd0);
      chk("flush busy", 64'(rdBusy), 64'b00);

      // Random traffic with frequent address collisions
      for (int n = 0; n < 400; n++) begin
         op(raddr(), raddr(), 2'($urandom_range(0, 3)), raddr(), raddr(),
            $urandom, $urandom, 1'($urandom_range(0, 1)), raddr(),
            ($urandom_range(0, 15) == 0));
      end

      // Asynchronous reset in the middle of the low clock phase
      op(7, 7, 2'b01, 7, 0, 32'hA5A5A5A5, 0, 1'b1, 8, 1'b0);
      idle_read(7, 8);
      chk("pre-rst x7", 64'(rdData[DW-1:0]), 64'hA5A5A5A5);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      chk("async rst x7", 64'(rdData[DW-1:0]), 64'd0);
      chk("async rst busy", 64'(rdBusy), 64'd0);
      chk("async rst cnt", 64'(busyCnt), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int n = 0; n < 50; n++) begin
         op(raddr(), raddr(), 2'($urandom_range(0, 3)), raddr(), raddr(),
            $urandom, $urandom, 1'($urandom_range(0, 1)), raddr(), 1'b0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
